// File: rtl/dma_master_pkg.sv
// Shared types and constants for the DMA master engine: FSM encoding,
// register offsets, CTRL/STAT bit positions and the config payload.
package dma_master_pkg;

    localparam int unsigned IDX_W = 2;
    localparam logic [14:0] DEF_BASE_ADDR = 15'h0260;

    // Byte offsets of the four word registers
    localparam logic [IDX_W:0] OFS_ADDR = 3'h0;
    localparam logic [IDX_W:0] OFS_DATA = 3'h2;
    localparam logic [IDX_W:0] OFS_CNT  = 3'h4;
    localparam logic [IDX_W:0] OFS_CTRL = 3'h6;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_DIR     = 1;
    localparam int unsigned CTRL_BYTE    = 2;
    localparam int unsigned CTRL_INC     = 3;
    localparam int unsigned CTRL_PRIO    = 4;
    localparam int unsigned CTRL_ABORT   = 5;
    localparam int unsigned CTRL_BUSY    = 8;
    localparam int unsigned CTRL_DONE    = 9;
    localparam int unsigned CTRL_ERR     = 10;
    localparam int unsigned CTRL_ABORTED = 11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RCAP = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Mirrors CTRL[4:1]
    typedef struct packed {
        logic prio;
        logic inc;
        logic byte_mode;
        logic dir;
    } cfg_t;

    function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                               input logic [15:0] din,
                                               input logic [1:0]  we);
        logic [15:0] m;
        m = {{8{we[1]}}, {8{we[0]}}};
        return (old_v & ~m) | (din & m);
    endfunction

endpackage

// File: rtl/dma_master_engine_if.sv
// Peripheral-bus and openMSP430 DMA-port signals of the DMA master engine.
interface dma_master_engine_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic        dma_wkup;
    logic [15:0] dma_dout;
    logic        dma_ready;
    logic        dma_resp;
    logic        irq_done;
    logic [15:0] trace;

    modport master (
        input  per_addr, per_din, per_en, per_we, dma_dout, dma_ready, dma_resp,
        output per_dout, dma_addr, dma_din, dma_en, dma_we, dma_priority, dma_wkup,
               irq_done, trace
    );

    modport slave (
        output per_addr, per_din, per_en, per_we, dma_dout, dma_ready, dma_resp,
        input  per_dout, dma_addr, dma_din, dma_en, dma_we, dma_priority, dma_wkup,
               irq_done, trace
    );
endinterface

// File: rtl/dma_master_regs.sv
// Register block of the DMA master: address decode, ADDR/DATA/CNT/CTRL
// storage, sticky status flags and the peripheral read mux.
module dma_master_regs
    import dma_master_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned DEC_WD    = 3,
    parameter int unsigned CNT_WD    = 8
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [13:0]       per_addr,
    input  logic [15:0]       per_din,
    input  logic              per_en,
    input  logic [1:0]        per_we,
    output logic [15:0]       per_dout,
    input  logic              busy,
    output logic              start_c,
    output logic              abort_c,
    output logic [15:0]       addr,
    output logic [15:0]       data,
    output logic [CNT_WD-1:0] cnt,
    output cfg_t              cfg,
    output cfg_t              cfg_nxt_c,
    input  logic              addr_upd,
    input  logic [15:0]       addr_new,
    input  logic              cnt_upd,
    input  logic [CNT_WD-1:0] cnt_new,
    input  logic              data_upd,
    input  logic [15:0]       data_new,
    input  logic              set_done,
    input  logic              set_err,
    input  logic              set_aborted
);

    logic           sel, wr, rd;
    logic [IDX_W:0] ofs;
    logic           wr_addr, wr_data, wr_cnt, wr_ctrl;
    logic           done, err, aborted;
    logic [15:0]    stat;

    assign sel = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign wr  = sel && (per_we != 2'b00);
    assign rd  = sel && (per_we == 2'b00);
    assign ofs = {IDX_W'(per_addr[DEC_WD-2:0]), 1'b0};

    // Configuration registers are frozen while a transfer is running
    assign wr_addr = wr && (ofs == OFS_ADDR) && !busy;
    assign wr_data = wr && (ofs == OFS_DATA) && !busy;
    assign wr_cnt  = wr && (ofs == OFS_CNT)  && !busy;
    assign wr_ctrl = wr && (ofs == OFS_CTRL);

    assign abort_c   = wr_ctrl && per_we[0] && per_din[CTRL_ABORT];
    assign start_c   = wr_ctrl && per_we[0] && per_din[CTRL_START] && !busy && !abort_c;
    assign cfg_nxt_c = (wr_ctrl && per_we[0] && !busy) ? cfg_t'(per_din[CTRL_PRIO:CTRL_DIR]) : cfg;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            addr    <= '0;
            data    <= '0;
            cnt     <= '0;
            cfg     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (wr_addr)       addr <= byte_merge(addr, per_din, per_we);
            else if (addr_upd) addr <= addr_new;
            if (wr_data)       data <= byte_merge(data, per_din, per_we);
            else if (data_upd) data <= data_new;
            if (wr_cnt)        cnt  <= CNT_WD'(byte_merge(16'(cnt), per_din, per_we));
            else if (cnt_upd)  cnt  <= cnt_new;
            cfg <= cfg_nxt_c;
            // Hardware set beats a simultaneous write-1-clear
            done    <= set_done    || (done    && !(wr_ctrl && per_we[1] && per_din[CTRL_DONE]));
            err     <= set_err     || (err     && !(wr_ctrl && per_we[1] && per_din[CTRL_ERR]));
            aborted <= set_aborted || (aborted && !(wr_ctrl && per_we[1] && per_din[CTRL_ABORTED]));
        end
    end

    always_comb begin
        stat                     = '0;
        stat[CTRL_PRIO:CTRL_DIR] = cfg;
        stat[CTRL_BUSY]          = busy;
        stat[CTRL_DONE]          = done;
        stat[CTRL_ERR]           = err;
        stat[CTRL_ABORTED]       = aborted;
        per_dout                 = '0;
        if (rd) begin
            case (ofs)
                OFS_ADDR: per_dout = addr;
                OFS_DATA: per_dout = data;
                OFS_CNT:  per_dout = 16'(cnt);
                OFS_CTRL: per_dout = stat;
                default:  per_dout = '0;
            endcase
        end
    end

endmodule

// File: rtl/dma_master_engine.sv
// DMA master engine: sequences programmed transfers onto the openMSP430 DMA
// port. Optional dma_ready history shift register via DMA_MASTER_TRACE_EN.
module dma_master_engine
    import dma_master_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned DEC_WD    = 3,
    parameter int unsigned CNT_WD    = 8
) (
    input  logic mclk,
    input  logic reset_n,
    dma_master_engine_if.master bus
);

    state_t            state, state_nxt;
    logic [15:0]       addr, data, addr_adv, addr_cur, rd_word;
    logic [CNT_WD-1:0] cnt, cnt_dec;
    cfg_t              cfg, cfg_nxt_c;
    logic              start_c, abort_c, busy, grant, xfer_ok, rd_lane;
    logic              en_d, en_q, prio_d, prio_q, wkup_d, wkup_q, irq_d, irq_q;
    logic [14:0]       addr_d, addr_q;
    logic [15:0]       din_d, din_q;
    logic [1:0]        we_d, we_q;

    assign busy     = (state != S_IDLE);
    assign grant    = (state == S_REQ) && bus.dma_ready;
    assign xfer_ok  = grant && !bus.dma_resp;
    assign addr_adv = addr + (cfg.byte_mode ? 16'd1 : 16'd2);
    assign cnt_dec  = cnt - CNT_WD'(1);
    // Address the next request will present, including an advance this cycle
    assign addr_cur = (xfer_ok && cfg.inc) ? addr_adv : addr;
    assign rd_word  = cfg.byte_mode ? {8'h00, rd_lane ? bus.dma_dout[15:8] : bus.dma_dout[7:0]}
                                    : bus.dma_dout;

    dma_master_regs #(
        .BASE_ADDR (BASE_ADDR),
        .DEC_WD    (DEC_WD),
        .CNT_WD    (CNT_WD)
    ) u_regs (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .per_addr    (bus.per_addr),
        .per_din     (bus.per_din),
        .per_en      (bus.per_en),
        .per_we      (bus.per_we),
        .per_dout    (bus.per_dout),
        .busy        (busy),
        .start_c     (start_c),
        .abort_c     (abort_c),
        .addr        (addr),
        .data        (data),
        .cnt         (cnt),
        .cfg         (cfg),
        .cfg_nxt_c   (cfg_nxt_c),
        .addr_upd    (xfer_ok && cfg.inc),
        .addr_new    (addr_adv),
        .cnt_upd     (xfer_ok),
        .cnt_new     (cnt_dec),
        .data_upd    ((state == S_RCAP) && !abort_c),
        .data_new    (rd_word),
        .set_done    ((state == S_DONE) && !abort_c),
        .set_err     ((state == S_ERR) && !abort_c),
        .set_aborted (abort_c && busy)
    );

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_c) state_nxt = (cnt == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                if (bus.dma_ready) begin
                    if (bus.dma_resp)                   state_nxt = S_ERR;
                    else if (cfg.dir)                   state_nxt = S_RCAP;
                    else if (cnt == CNT_WD'(1))         state_nxt = S_DONE;
                    else                                state_nxt = S_REQ;
                end
            end
            S_RCAP:         state_nxt = (cnt == '0) ? S_DONE : S_REQ;
            S_DONE, S_ERR:  state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
        if (abort_c && busy) state_nxt = S_IDLE;
    end

    // Next values of the registered DMA port, derived from the upcoming state
    always_comb begin
        en_d   = 1'b0;
        addr_d = '0;
        din_d  = '0;
        we_d   = 2'b00;
        prio_d = 1'b0;
        wkup_d = (state_nxt != S_IDLE);
        irq_d  = ((state == S_DONE) || (state == S_ERR)) && !abort_c;
        if (state_nxt == S_REQ) begin
            en_d   = 1'b1;
            addr_d = addr_cur[15:1];
            prio_d = cfg_nxt_c.prio;
            if (!cfg_nxt_c.dir) begin
                if (cfg_nxt_c.byte_mode) begin
                    we_d  = {addr_cur[0], ~addr_cur[0]};
                    din_d = {data[7:0], data[7:0]};
                end else begin
                    we_d  = 2'b11;
                    din_d = data;
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 2'b00;
            prio_q  <= 1'b0;
            wkup_q  <= 1'b0;
            irq_q   <= 1'b0;
            rd_lane <= 1'b0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            we_q   <= we_d;
            prio_q <= prio_d;
            wkup_q <= wkup_d;
            irq_q  <= irq_d;
            if (grant) rd_lane <= addr[0];
        end
    end

    assign bus.dma_en       = en_q;
    assign bus.dma_addr     = addr_q;
    assign bus.dma_din      = din_q;
    assign bus.dma_we       = we_q;
    assign bus.dma_priority = prio_q;
    assign bus.dma_wkup     = wkup_q;
    assign bus.irq_done     = irq_q;

`ifdef DMA_MASTER_TRACE_EN
    logic [15:0] trace_q;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) trace_q <= '0;
        else          trace_q <= {trace_q[14:0], bus.dma_en & bus.dma_ready};
    end

    assign bus.trace = trace_q;
`else
    assign bus.trace = '0;
`endif

endmodule

// File: tb/tb_dma_master_engine.sv
// Directed self-checking bench for dma_master_engine (honours DMA_MASTER_TRACE_EN).
`timescale 1ns/1ps
module tb_dma_master_engine;
    import dma_master_pkg::*;

    logic mclk    = 1'b0;
    logic reset_n = 1'b0;
    always #5 mclk = ~mclk;

    dma_master_engine_if bus ();

    dma_master_engine dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic        mon_clr = 1'b1;
    int          grants, en_cycles, irqs;
    logic [14:0] g_addr [0:7];
    logic [1:0]  g_we   [0:7];
    logic [15:0] g_din  [0:7];

    always @(posedge mclk) begin
        if (mon_clr) begin
            grants    = 0;
            en_cycles = 0;
            irqs      = 0;
        end else begin
            if (bus.dma_en) en_cycles++;
            if (bus.dma_en && bus.dma_ready) begin
                if (grants < 8) begin
                    g_addr[grants] = bus.dma_addr;
                    g_we[grants]   = bus.dma_we;
                    g_din[grants]  = bus.dma_din;
                end
                grants++;
            end
            if (bus.irq_done) irqs++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] ofs, input logic [15:0] d, input logic [1:0] we);
        bus.per_addr = 14'h0130 + 14'(ofs >> 1);
        bus.per_din  = d;
        bus.per_we   = we;
        bus.per_en   = 1'b1;
        tick();
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] ofs, input logic [15:0] exp);
        bus.per_addr = 14'h0130 + 14'(ofs >> 1);
        bus.per_we   = 2'b00;
        bus.per_en   = 1'b1;
        @(negedge mclk);
        chk(tag, 32'(bus.per_dout), 32'(exp));
        tick();
        bus.per_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.dma_wkup && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.dma_wkup), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_trace;
        bus.per_addr  = '0;
        bus.per_din   = '0;
        bus.per_en    = 1'b0;
        bus.per_we    = 2'b00;
        bus.dma_dout  = '0;
        bus.dma_ready = 1'b0;
        bus.dma_resp  = 1'b0;

        // Reset state
        tick(2);
        chk("rst_en",   32'(bus.dma_en), 32'h0);
        chk("rst_we",   32'(bus.dma_we), 32'h0);
        chk("rst_addr", 32'(bus.dma_addr), 32'h0);
        chk("rst_din",  32'(bus.dma_din), 32'h0);
        chk("rst_prio", 32'(bus.dma_priority), 32'h0);
        chk("rst_wkup", 32'(bus.dma_wkup), 32'h0);
        chk("rst_irq",  32'(bus.irq_done), 32'h0);
        chk("rst_trace", 32'(bus.trace), 32'h0);
        reset_n = 1'b1;
        tick();
        rd_chk("rst_ctrl", OFS_CTRL, 16'h0000);
        rd_chk("rst_cnt",  OFS_CNT,  16'h0000);

        // Word write burst with increment and priority
        bus.dma_ready = 1'b1;
        reg_wr(OFS_ADDR, 16'h0200, 2'b11);
        reg_wr(OFS_DATA, 16'hA5A5, 2'b11);
        reg_wr(OFS_CNT,  16'h0003, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0019, 2'b01);
        chk("w_en",   32'(bus.dma_en), 32'h1);
        chk("w_we",   32'(bus.dma_we), 32'h3);
        chk("w_prio", 32'(bus.dma_priority), 32'h1);
        chk("w_wkup", 32'(bus.dma_wkup), 32'h1);
        wait_idle("w_idle", 20);
        tick(2);
        chk("w_grants", 32'(grants), 32'd3);
        chk("w_a0", 32'(g_addr[0]), 32'h100);
        chk("w_a1", 32'(g_addr[1]), 32'h101);
        chk("w_a2", 32'(g_addr[2]), 32'h102);
        chk("w_din2", 32'(g_din[2]), 32'hA5A5);
        chk("w_irq", 32'(irqs), 32'd1);
        rd_chk("w_addr", OFS_ADDR, 16'h0206);
        rd_chk("w_cnt",  OFS_CNT,  16'h0000);
        rd_chk("w_ctrl", OFS_CTRL, 16'h0218);

        // Unselected block reads as zero
        bus.per_addr = 14'h0100;
        bus.per_en   = 1'b1;
        @(negedge mclk);
        chk("unsel_rd", 32'(bus.per_dout), 32'h0);
        tick();
        bus.per_en = 1'b0;
        reg_wr(OFS_CTRL, 16'h0E00, 2'b10);

        // Byte write to odd address
        reg_wr(OFS_ADDR, 16'h0201, 2'b11);
        reg_wr(OFS_DATA, 16'h003C, 2'b11);
        reg_wr(OFS_CNT,  16'h0001, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0005, 2'b11);
        chk("b_we",   32'(bus.dma_we), 32'h2);
        chk("b_din",  32'(bus.dma_din), 32'h3C3C);
        chk("b_addr", 32'(bus.dma_addr), 32'h100);
        wait_idle("b_idle", 20);
        tick(2);
        chk("b_grants", 32'(grants), 32'd1);
        chk("b_gwe", 32'(g_we[0]), 32'h2);
        rd_chk("b_addr_end", OFS_ADDR, 16'h0201);
        rd_chk("b_ctrl", OFS_CTRL, 16'h0204);
        reg_wr(OFS_CTRL, 16'h0E00, 2'b10);

        // Word read with a 4-cycle ready stall
        bus.dma_ready = 1'b0;
        reg_wr(OFS_ADDR, 16'h0300, 2'b11);
        reg_wr(OFS_CNT,  16'h0001, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0003, 2'b11);
        tick(3);
        chk("r_hold_en",   32'(bus.dma_en), 32'h1);
        chk("r_hold_addr", 32'(bus.dma_addr), 32'h180);
        chk("r_hold_we",   32'(bus.dma_we), 32'h0);
        tick();
        bus.dma_ready = 1'b1;
        bus.dma_dout  = 16'h1234;
        tick();
        bus.dma_ready = 1'b0;
        chk("r_en_cycles", 32'(en_cycles), 32'd5);
        tick();
        rd_chk("r_data", OFS_DATA, 16'h1234);
        wait_idle("r_idle", 20);
        tick(2);
        chk("r_irq", 32'(irqs), 32'd1);
        rd_chk("r_ctrl", OFS_CTRL, 16'h0202);
        reg_wr(OFS_CTRL, 16'h0E00, 2'b10);

        // Error response on the second of four transfers
        bus.dma_ready = 1'b1;
        reg_wr(OFS_ADDR, 16'h0400, 2'b11);
        reg_wr(OFS_DATA, 16'h1111, 2'b11);
        reg_wr(OFS_CNT,  16'h0004, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0009, 2'b11);
        tick();
        bus.dma_resp = 1'b1;
        tick();
        bus.dma_resp = 1'b0;
        wait_idle("e_idle", 20);
        tick(2);
        chk("e_grants", 32'(grants), 32'd2);
        chk("e_irq", 32'(irqs), 32'd1);
        rd_chk("e_cnt",  OFS_CNT,  16'h0003);
        rd_chk("e_addr", OFS_ADDR, 16'h0402);
        rd_chk("e_ctrl", OFS_CTRL, 16'h0408);
        reg_wr(OFS_CTRL, 16'h0E00, 2'b10);

        // Abort during a stalled request
        bus.dma_ready = 1'b0;
        reg_wr(OFS_ADDR, 16'h0500, 2'b11);
        reg_wr(OFS_CNT,  16'h0002, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0001, 2'b11);
        tick(2);
        reg_wr(OFS_CTRL, 16'h0020, 2'b01);
        chk("a_en",   32'(bus.dma_en), 32'h0);
        chk("a_wkup", 32'(bus.dma_wkup), 32'h0);
        tick(3);
        chk("a_irq", 32'(irqs), 32'd0);
        chk("a_grants", 32'(grants), 32'd0);
        rd_chk("a_ctrl", OFS_CTRL, 16'h0800);
        rd_chk("a_cnt",  OFS_CNT,  16'h0002);
        reg_wr(OFS_CTRL, 16'h0E00, 2'b10);

        // START with CNT==0 completes without bus activity
        reg_wr(OFS_CNT, 16'h0000, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0001, 2'b11);
        wait_idle("z_idle", 20);
        tick(2);
        chk("z_en_cycles", 32'(en_cycles), 32'd0);
        chk("z_irq", 32'(irqs), 32'd1);
        rd_chk("z_ctrl", OFS_CTRL, 16'h0200);
        reg_wr(OFS_CTRL, 16'h0E00, 2'b10);

        // START and ABORT together: nothing starts
        reg_wr(OFS_CNT, 16'h0001, 2'b11);
        mon_reset();
        reg_wr(OFS_CTRL, 16'h0021, 2'b01);
        tick(2);
        chk("sa_en_cycles", 32'(en_cycles), 32'd0);
        chk("sa_irq", 32'(irqs), 32'd0);
        rd_chk("sa_ctrl", OFS_CTRL, 16'h0000);

        // Asynchronous reset mid-burst
        reg_wr(OFS_ADDR, 16'h0600, 2'b11);
        reg_wr(OFS_CNT,  16'h0003, 2'b11);
        reg_wr(OFS_CTRL, 16'h0009, 2'b11);
        tick();
        chk("rb_en", 32'(bus.dma_en), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_en",   32'(bus.dma_en), 32'h0);
        chk("rm_addr", 32'(bus.dma_addr), 32'h0);
        chk("rm_din",  32'(bus.dma_din), 32'h0);
        chk("rm_wkup", 32'(bus.dma_wkup), 32'h0);
        @(negedge mclk);
        reset_n = 1'b1;
        tick();
        rd_chk("rm_ctrl", OFS_CTRL, 16'h0000);
        rd_chk("rm_addr_reg", OFS_ADDR, 16'h0000);
        rd_chk("rm_data_reg", OFS_DATA, 16'h0000);

        // Three back-to-back grants into the trace history
`ifdef DMA_MASTER_TRACE_EN
        exp_trace = 16'h0007;
`else
        exp_trace = 16'h0000;
`endif
        bus.dma_ready = 1'b1;
        reg_wr(OFS_ADDR, 16'h0700, 2'b11);
        reg_wr(OFS_CNT,  16'h0003, 2'b11);
        reg_wr(OFS_CTRL, 16'h0009, 2'b11);
        tick(3);
        chk("trace", 32'(bus.trace), 32'(exp_trace));
        wait_idle("t_idle", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
